// File: rtl/rv32i_pkg.sv
// Shared RV32I encodings for the writeback stage: result source select and load funct3 codes.
package rv32i_pkg;

    typedef enum logic [1:0] {
        RES_ALU = 2'b00,
        RES_MEM = 2'b01,
        RES_PC4 = 2'b10
    } result_src_e;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/load_extend.sv
// Aligns a word-aligned memory read to the addressed byte/halfword and sign- or zero-extends it.
module load_extend
    import rv32i_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] word_i,
    input  logic [1:0]      off_i,
    input  logic [2:0]      funct3_i,
    output logic [XLEN-1:0] data_o
);

    logic signed [7:0]  byte_s;
    logic signed [15:0] half_s;

    // Lane select then extension; halfword loads ignore the low offset bit.
    always_comb begin
        byte_s = word_i[{off_i, 3'b000} +: 8];
        half_s = off_i[1] ? word_i[31:16] : word_i[15:0];
        case (funct3_i)
            F3_LB:   data_o = {{(XLEN-8){byte_s[7]}}, byte_s};
            F3_LH:   data_o = {{(XLEN-16){half_s[15]}}, half_s};
            F3_LBU:  data_o = {{(XLEN-8){1'b0}}, byte_s};
            F3_LHU:  data_o = {{(XLEN-16){1'b0}}, half_s};
            default: data_o = word_i;
        endcase
    end

endmodule

// File: rtl/memory_writeback.sv
// MEM/WB pipeline register with writeback result selection and a retired-instruction counter.
module memory_writeback
    import rv32i_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_m,
    input  logic [4:0]       rd_m,
    input  logic             reg_write_m,
    input  logic [1:0]       result_src_m,
    input  logic [2:0]       funct3_m,
    input  logic [XLEN-1:0]  alu_result_m,
    input  logic [XLEN-1:0]  read_data_m,
    input  logic [XLEN-1:0]  pc_plus4_m,
    input  logic             stall_w,
    input  logic             flush_w,
    output logic             valid_w,
    output logic [4:0]       rd_w,
    output logic             reg_write_w,
    output logic [XLEN-1:0]  result_w,
    output logic [CNT_W-1:0] instret_w
);

    logic             valid_q;
    logic [4:0]       rd_q;
    logic             reg_write_q;
    logic [1:0]       src_q;
    logic [2:0]       funct3_q;
    logic [XLEN-1:0]  alu_q;
    logic [XLEN-1:0]  rdata_q;
    logic [XLEN-1:0]  pc4_q;
    logic [CNT_W-1:0] instret_q;
    logic [CNT_W-1:0] instret_d;
    logic [XLEN-1:0]  load_val;

    assign instret_d = instret_q + CNT_W'(1);

    // Stage registers and counter; flush beats stall, and the departing instruction
    // is counted whenever the stage is not stalled.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q     <= 1'b0;
            rd_q        <= '0;
            reg_write_q <= 1'b0;
            src_q       <= '0;
            funct3_q    <= '0;
            alu_q       <= '0;
            rdata_q     <= '0;
            pc4_q       <= '0;
            instret_q   <= '0;
        end else begin
            if (valid_q && !stall_w) begin
                instret_q <= instret_d;
            end
            if (flush_w || !stall_w) begin
                src_q    <= result_src_m;
                funct3_q <= funct3_m;
                alu_q    <= alu_result_m;
                rdata_q  <= read_data_m;
                pc4_q    <= pc_plus4_m;
            end
            if (flush_w) begin
                valid_q     <= 1'b0;
                reg_write_q <= 1'b0;
                rd_q        <= '0;
            end else if (!stall_w) begin
                valid_q     <= valid_m;
                reg_write_q <= reg_write_m;
                rd_q        <= rd_m;
            end
        end
    end

    load_extend #(.XLEN(XLEN)) u_load_extend (
        .word_i   (rdata_q),
        .off_i    (alu_q[1:0]),
        .funct3_i (funct3_q),
        .data_o   (load_val)
    );

    // Writeback mux driven only by registered fields; the reserved code falls back to ALU.
    always_comb begin
        case (src_q)
            RES_MEM: result_w = load_val;
            RES_PC4: result_w = pc4_q;
            default: result_w = alu_q;
        endcase
    end

    assign valid_w     = valid_q;
    assign rd_w        = rd_q;
    assign reg_write_w = reg_write_q & valid_q & (rd_q != 5'd0);
    assign instret_w   = instret_q;

endmodule

// File: tb/tb_memory_writeback.sv
// Directed and randomized bench for memory_writeback with a behavioural reference model.
module tb_memory_writeback;

    localparam int CW = 8;

    logic          clk;
    logic          rst;
    logic          valid_m;
    logic [4:0]    rd_m;
    logic          reg_write_m;
    logic [1:0]    result_src_m;
    logic [2:0]    funct3_m;
    logic [31:0]   alu_result_m;
    logic [31:0]   read_data_m;
    logic [31:0]   pc_plus4_m;
    logic          stall_w;
    logic          flush_w;
    logic          valid_w;
    logic [4:0]    rd_w;
    logic          reg_write_w;
    logic [31:0]   result_w;
    logic [CW-1:0] instret_w;

    int total = 0;
    int bad   = 0;

    // Reference model: contents of the W stage and the retired count.
    logic          m_valid, m_we;
    logic [4:0]    m_rd;
    logic [1:0]    m_src;
    logic [2:0]    m_f3;
    logic [31:0]   m_alu, m_rdata, m_pc4;
    logic [CW-1:0] m_cnt;

    memory_writeback #(.XLEN(32), .CNT_W(CW)) dut (
        .clk          (clk),
        .rst          (rst),
        .valid_m      (valid_m),
        .rd_m         (rd_m),
        .reg_write_m  (reg_write_m),
        .result_src_m (result_src_m),
        .funct3_m     (funct3_m),
        .alu_result_m (alu_result_m),
        .read_data_m  (read_data_m),
        .pc_plus4_m   (pc_plus4_m),
        .stall_w      (stall_w),
        .flush_w      (flush_w),
        .valid_w      (valid_w),
        .rd_w         (rd_w),
        .reg_write_w  (reg_write_w),
        .result_w     (result_w),
        .instret_w    (instret_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] model_load(input logic [31:0] w, input logic [31:0] addr,
                                               input logic [2:0] f3);
        longint off, b, h, v;
        off = longint'(addr % 4);
        b = longint'((w >> (8 * off)) & 32'hFF);
        h = longint'((w >> (16 * (off / 2))) & 32'hFFFF);
        case (f3)
            3'b000:  v = (b >= 128) ? b - 256 : b;
            3'b100:  v = b;
            3'b001:  v = (h >= 32768) ? h - 65536 : h;
            3'b101:  v = h;
            default: v = longint'(w);
        endcase
        return 32'(v);
    endfunction

    function automatic logic [31:0] model_result();
        if (m_src == 2'd1) return model_load(m_rdata, m_alu, m_f3);
        if (m_src == 2'd2) return m_pc4;
        return m_alu;
    endfunction

    task automatic model_clear();
        m_valid = 0; m_we = 0; m_rd = 0; m_src = 0; m_f3 = 0;
        m_alu = 0; m_rdata = 0; m_pc4 = 0; m_cnt = 0;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".valid"}, 64'(valid_w), 64'(m_valid));
        chk({tag, ".rd"}, 64'(rd_w), 64'(m_rd));
        chk({tag, ".we"}, 64'(reg_write_w), 64'(m_we && m_valid && (m_rd != 0)));
        chk({tag, ".result"}, 64'(result_w), 64'(model_result()));
        chk({tag, ".instret"}, 64'(instret_w), 64'(m_cnt));
    endtask

    // One clock edge: advance the model with the inputs present at the edge.
    task automatic step();
        @(posedge clk);
        if (rst) begin
            if (m_valid && !stall_w) m_cnt = m_cnt + 1'b1;
            if (flush_w || !stall_w) begin
                m_src = result_src_m; m_f3 = funct3_m;
                m_alu = alu_result_m; m_rdata = read_data_m; m_pc4 = pc_plus4_m;
            end
            if (flush_w) begin
                m_valid = 0; m_we = 0; m_rd = 0;
            end else if (!stall_w) begin
                m_valid = valid_m; m_we = reg_write_m; m_rd = rd_m;
            end
        end
        #1;
    endtask

    task automatic drive(input logic v, input logic [4:0] rd, input logic we,
                         input logic [1:0] src, input logic [2:0] f3, input logic [31:0] alu,
                         input logic [31:0] rdata, input logic [31:0] pc4);
        valid_m = v; rd_m = rd; reg_write_m = we; result_src_m = src; funct3_m = f3;
        alu_result_m = alu; read_data_m = rdata; pc_plus4_m = pc4;
        stall_w = 0; flush_w = 0;
    endtask

    task automatic drive_random();
        valid_m = 1'($urandom); rd_m = 5'($urandom); reg_write_m = 1'($urandom);
        result_src_m = 2'($urandom); funct3_m = 3'($urandom);
        alu_result_m = $urandom; read_data_m = $urandom; pc_plus4_m = $urandom;
    endtask

    initial begin
        int guard;
        model_clear();
        rst = 0;
        drive_random();
        stall_w = 1'($urandom); flush_w = 1'($urandom);

        // Reset held with random inputs: everything stays zero.
        for (int i = 0; i < 3; i++) begin
            step();
            drive_random();
            stall_w = 1'($urandom); flush_w = 1'($urandom);
        end
        check_all("reset");
        chk("reset.result0", 64'(result_w), 64'h0);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        #2 rst = 1;
        #1 check_all("release");
        chk("release.instret0", 64'(instret_w), 64'h0);

        // Byte loads.
        drive(1, 5'd5, 1, 2'b01, 3'b000, 32'h0000_1003, 32'h80FF_7F01, 32'h0);
        step(); check_all("lb3");
        chk("lb3.lit", 64'(result_w), 64'hFFFF_FF80);
        drive(1, 5'd5, 1, 2'b01, 3'b100, 32'h0000_1003, 32'h80FF_7F01, 32'h0);
        step(); check_all("lbu3");
        chk("lbu3.lit", 64'(result_w), 64'h0000_0080);
        drive(1, 5'd5, 1, 2'b01, 3'b000, 32'h0000_1001, 32'h80FF_7F01, 32'h0);
        step(); check_all("lb1");
        chk("lb1.lit", 64'(result_w), 64'h0000_007F);

        // Halfword and word loads.
        drive(1, 5'd6, 1, 2'b01, 3'b001, 32'h0000_2002, 32'h8001_1234, 32'h0);
        step(); chk("lh2.lit", 64'(result_w), 64'hFFFF_8001);
        drive(1, 5'd6, 1, 2'b01, 3'b101, 32'h0000_2003, 32'h8001_1234, 32'h0);
        step(); chk("lhu3.lit", 64'(result_w), 64'h0000_8001);
        drive(1, 5'd6, 1, 2'b01, 3'b010, 32'h0000_2002, 32'h8001_1234, 32'h0);
        step(); chk("lw.lit", 64'(result_w), 64'h8001_1234);
        check_all("lw");

        // Link value and x0 suppression.
        drive(1, 5'd1, 1, 2'b10, 3'b000, 32'hDEAD_BEEF, 32'h0, 32'h0000_0104);
        step(); check_all("jal");
        chk("jal.res", 64'(result_w), 64'h104);
        chk("jal.we", 64'(reg_write_w), 64'h1);
        drive(1, 5'd0, 1, 2'b10, 3'b000, 32'h0, 32'h0, 32'h0000_0104);
        step(); chk("jal_x0.we", 64'(reg_write_w), 64'h0);
        drive(1, 5'd9, 1, 2'b11, 3'b000, 32'h1234_5678, 32'h0, 32'h0);
        step(); chk("rsvd.res", 64'(result_w), 64'h1234_5678);

        // Stall three cycles with new inputs presented: outputs frozen.
        drive(1, 5'd12, 1, 2'b00, 3'b000, 32'hCAFE_0001, 32'h0, 32'h0);
        step(); check_all("pre_stall");
        drive(1, 5'd13, 1, 2'b10, 3'b000, 32'h0, 32'h0, 32'h0000_0400);
        stall_w = 1;
        for (int i = 0; i < 3; i++) begin
            step(); check_all("stall");
            chk("stall.frozen", 64'(result_w), 64'hCAFE_0001);
        end
        // Flush without stall: departing instruction counted, bubble inserted.
        stall_w = 0; flush_w = 1;
        step(); check_all("flush");
        chk("flush.valid", 64'(valid_w), 64'h0);
        chk("flush.we", 64'(reg_write_w), 64'h0);

        // Flush together with stall: still a bubble, no count.
        drive(1, 5'd14, 1, 2'b00, 3'b000, 32'h11, 32'h0, 32'h0);
        step();
        stall_w = 1; flush_w = 1;
        step(); check_all("flush_stall");

        // Counter wrap through all-ones.
        drive(1, 5'd3, 1, 2'b00, 3'b000, 32'h7, 32'h0, 32'h0);
        guard = 0;
        while (m_cnt != {CW{1'b1}} && guard < 600) begin
            step(); guard++;
        end
        chk("wrap.reach", 64'(instret_w), 64'(2**CW - 1));
        step(); check_all("wrap");
        chk("wrap.zero", 64'(instret_w), 64'h0);

        // Randomized traffic with occasional stalls and flushes.
        for (int i = 0; i < 400; i++) begin
            drive_random();
            stall_w = ($urandom_range(0, 3) == 0);
            flush_w = ($urandom_range(0, 5) == 0);
            step(); check_all("rand");
        end

        // Asynchronous reset during stall+flush clears everything without a clock edge.
        stall_w = 1; flush_w = 1;
        @(negedge clk);
        rst = 0;
        model_clear();
        #1 check_all("async_rst");
        chk("async_rst.cnt", 64'(instret_w), 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
